mgt_01_ctx_ireg_file: RTL and testbench

- Parametrised integer register file: NRD combinational read ports, one write port, register 0 hardwired to zero.
- Built-in context engine for interrupt entry and exit.
- Save streams registers 1..NREGS-1 out over a valid/ready interface, one word per handshake.
- Restore loads registers 1..NREGS-1 from a valid/ready stream.
- Sits in the decode/writeback stage; the interrupt controller drives the context streams.

---
 rtl/mgt_01_ctx_ireg_file.sv | 152 +++++++++++++++
 tb/tb_mgt_01_ctx_ireg_file.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgt_01_ctx_ireg_file.sv
// Integer register file with x0 hardwired to zero, NRD combinational read ports,
// and a context engine that streams registers 1..NREGS-1 out (save) or in (restore).
module mgt_01_ctx_ireg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         w_addr_i,
    input  logic [XLEN-1:0]       w_data_i,
    input  logic [NRD*AW-1:0]     r_addr_i,
    output logic [NRD*XLEN-1:0]   r_data_o,
    input  logic                  save_start_i,
    input  logic                  restore_start_i,
    output logic                  ctx_valid_o,
    input  logic                  ctx_ready_i,
    output logic [AW-1:0]         ctx_addr_o,
    output logic [XLEN-1:0]       ctx_data_o,
    input  logic                  ctx_valid_i,
    output logic                  ctx_ready_o,
    input  logic [XLEN-1:0]       ctx_data_i,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One extra counter bit keeps NREGS == 2**AW from wrapping before the terminal compare.
    localparam logic [AW:0] NREGS_C = (AW+1)'(NREGS);
    localparam logic [AW:0] LAST_C  = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t              state_r;
    state_t              state_nx_s;
    logic [AW:0]         idx_r;
    logic [AW:0]         idx_nx_s;
    logic [XLEN-1:0]     regs_r [NREGS];
    logic                valid_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic                core_wr_s;
    logic                restore_wr_s;
    logic                hs_s;
    logic [AW-1:0]       ra_s;

    assign core_wr_s    = we_i & clk_en_i & ~busy_r & (w_addr_i != {AW{1'b0}})
                        & ({1'b0, w_addr_i} < NREGS_C);
    assign restore_wr_s = (state_r == ST_RESTORE) & ctx_valid_i;
    assign hs_s         = ((state_r == ST_SAVE) & ctx_ready_i) | restore_wr_s;

    assign ctx_valid_o = valid_r;
    assign ctx_ready_o = ready_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign ctx_addr_o  = idx_r[AW-1:0];
    assign ctx_data_o  = regs_r[idx_r[AW-1:0]];

    // Next-state and index logic of the context engine.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (save_start_i) begin
                    state_nx_s = ST_SAVE;
                    idx_nx_s   = ONE_C;
                end else if (restore_start_i) begin
                    state_nx_s = ST_RESTORE;
                    idx_nx_s   = ONE_C;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (hs_s) begin
                    if (idx_r == LAST_C) begin
                        state_nx_s = ST_DONE;
                        idx_nx_s   = ONE_C;
                    end else begin
                        idx_nx_s = idx_r + ONE_C;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, index and registered stream/status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            idx_r   <= ONE_C;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (clk_en_i) begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            valid_r <= (state_nx_s == ST_SAVE);
            ready_r <= (state_nx_s == ST_RESTORE);
            busy_r  <= (state_nx_s == ST_SAVE) | (state_nx_s == ST_RESTORE);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Register array: restore stream and core port never write in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (clk_en_i) begin
            if (restore_wr_s) begin
                regs_r[idx_r[AW-1:0]] <= ctx_data_i;
            end else if (core_wr_s) begin
                regs_r[w_addr_i] <= w_data_i;
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        r_data_o = {(NRD*XLEN){1'b0}};
        ra_s     = {AW{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            ra_s = r_addr_i[k*AW +: AW];
            if ((ra_s == {AW{1'b0}}) || ({1'b0, ra_s} >= NREGS_C)) begin
                r_data_o[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && core_wr_s && (w_addr_i == ra_s)) begin
                r_data_o[k*XLEN +: XLEN] = w_data_i;
            end else begin
                r_data_o[k*XLEN +: XLEN] = regs_r[ra_s];
            end
        end
    end

endmodule

// File: tb/tb_mgt_01_ctx_ireg_file.sv
// Directed bench: a spec-level model checked every cycle on the default instance,
// plus literal expectations and a second instance with NREGS=16, NRD=3, BYPASS=0.
module tb_mgt_01_ctx_ireg_file;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int N2 = 16;

    logic clk, rst, clk_en, we, save_start, restore_start;
    logic [AW-1:0] w_addr;
    logic [31:0] w_data;
    logic [2*AW-1:0] r_addr;
    logic [63:0] r_data;
    logic cv_o, cr_i, cv_i, cr_o, busy, done;
    logic [AW-1:0] ctx_addr;
    logic [31:0] ctx_data, cd_i;

    logic b_clk_en, b_we, b_save_start, b_restore_start;
    logic [3:0] b_w_addr;
    logic [31:0] b_w_data;
    logic [11:0] b_r_addr;
    logic [95:0] b_r_data;
    logic b_cv_o, b_cr_i, b_cv_i, b_cr_o, b_busy, b_done;
    logic [3:0] b_ctx_addr;
    logic [31:0] b_ctx_data, b_cd_i;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int done_cnt = 0;
    logic [31:0] q_addr[$], q_data[$], bq_addr[$], bq_data[$];

    // model state: kind 0 none, 1 saving, 2 restoring; pos = next register in the stream
    logic [31:0] m_regs [N];
    int m_kind, m_pos;
    logic m_done;

    mgt_01_ctx_ireg_file dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .we_i(we), .w_addr_i(w_addr),
        .w_data_i(w_data), .r_addr_i(r_addr), .r_data_o(r_data),
        .save_start_i(save_start), .restore_start_i(restore_start),
        .ctx_valid_o(cv_o), .ctx_ready_i(cr_i), .ctx_addr_o(ctx_addr), .ctx_data_o(ctx_data),
        .ctx_valid_i(cv_i), .ctx_ready_o(cr_o), .ctx_data_i(cd_i),
        .busy_o(busy), .done_o(done));

    mgt_01_ctx_ireg_file #(.NREGS(N2), .NRD(3), .BYPASS(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .clk_en_i(b_clk_en), .we_i(b_we), .w_addr_i(b_w_addr),
        .w_data_i(b_w_data), .r_addr_i(b_r_addr), .r_data_o(b_r_data),
        .save_start_i(b_save_start), .restore_start_i(b_restore_start),
        .ctx_valid_o(b_cv_o), .ctx_ready_i(b_cr_i), .ctx_addr_o(b_ctx_addr),
        .ctx_data_o(b_ctx_data), .ctx_valid_i(b_cv_i), .ctx_ready_o(b_cr_o),
        .ctx_data_i(b_cd_i), .busy_o(b_busy), .done_o(b_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd_chk(input string name, input int a, input logic [31:0] exp);
        r_addr = {5'd0, 5'(a)};
        #1 chk(name, r_data[31:0], exp);
        tick();
    endtask

    // Behavioural model of the default instance, advanced at every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_regs[i] <= 32'd0;
            m_kind <= 0;
            m_pos  <= 1;
            m_done <= 1'b0;
        end else if (clk_en) begin
            m_done <= 1'b0;
            if (m_kind == 0 && we && w_addr != 5'd0) m_regs[w_addr] <= w_data;
            if (m_kind == 0 && !m_done) begin
                if (save_start) begin m_kind <= 1; m_pos <= 1; end
                else if (restore_start) begin m_kind <= 2; m_pos <= 1; end
            end else if (m_kind != 0) begin
                if ((m_kind == 1 && cr_i) || (m_kind == 2 && cv_i)) begin
                    if (m_kind == 2) m_regs[m_pos] <= cd_i;
                    if (m_pos == N - 1) begin m_kind <= 0; m_done <= 1'b1; end
                    else m_pos <= m_pos + 1;
                end
            end
        end
    end

    // Stream capture and done counting.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (cv_o && cr_i && clk_en) begin
            q_addr.push_back(32'(ctx_addr));
            q_data.push_back(ctx_data);
        end
        if (b_cv_o && b_cr_i) begin
            bq_addr.push_back(32'(b_ctx_addr));
            bq_data.push_back(b_ctx_data);
        end
    end

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [31:0] e;
        #3;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                a = r_addr[k*AW +: AW];
                if (a == 5'd0) e = 32'd0;
                else if (we && clk_en && m_kind == 0 && w_addr == a) e = w_data;
                else e = m_regs[a];
                chk("model_rdata", r_data[k*32 +: 32], e);
            end
            chk("model_busy", 32'(busy), 32'(m_kind != 0));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_ctx_valid", 32'(cv_o), 32'(m_kind == 1));
            chk("model_ctx_ready", 32'(cr_o), 32'(m_kind == 2));
            if (m_kind == 1) begin
                chk("model_ctx_addr", 32'(ctx_addr), 32'(m_pos));
                chk("model_ctx_data", ctx_data, m_regs[m_pos]);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, sent, d0;
        rst = 1'b1; clk_en = 1'b1; we = 1'b0; w_addr = 5'd0; w_data = 32'd0;
        r_addr = 10'd0; save_start = 1'b0; restore_start = 1'b0;
        cr_i = 1'b0; cv_i = 1'b0; cd_i = 32'd0;
        b_clk_en = 1'b1; b_we = 1'b0; b_w_addr = 4'd0; b_w_data = 32'd0; b_r_addr = 12'd0;
        b_save_start = 1'b0; b_restore_start = 1'b0; b_cr_i = 1'b0; b_cv_i = 1'b0;
        b_cd_i = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1 chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Load i*0x11, then reset clears everything
        for (int i = 1; i < N; i++) begin
            we = 1'b1; w_addr = 5'(i); w_data = 32'(i * 17); tick();
        end
        we = 1'b0;
        rd_chk("load_x7", 7, 32'h77);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 1; i < N; i++) rd_chk("rst_read", i, 32'd0);

        // x0 stays zero, forwarding on port 1
        we = 1'b1; w_addr = 5'd0; w_data = 32'hDEADBEEF; r_addr = 10'd0;
        #1 chk("x0_same_cycle", r_data[31:0], 32'd0);
        tick(); we = 1'b0;
        #1 chk("x0_after", r_data[31:0], 32'd0);
        we = 1'b1; w_addr = 5'd5; w_data = 32'h12345678; r_addr = {5'd5, 5'd0};
        #1 chk("bypass_x5", r_data[63:32], 32'h12345678);
        tick(); we = 1'b0;

        // Save with alternating ready
        for (int i = 1; i < N; i++) begin
            we = 1'b1; w_addr = 5'(i); w_data = 32'h100 + 32'(i); tick();
        end
        we = 1'b0;
        q_addr.delete(); q_data.delete(); d0 = done_cnt;
        save_start = 1'b1; tick(); save_start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            cr_i = (n % 2 == 0);
            restore_start = (n == 3);
            we = (n == 5); w_addr = 5'd2; w_data = 32'h00000BAD;
            tick(); n++;
        end
        chk("save_timeout", 32'(n < 200), 32'd1);
        cr_i = 1'b0; restore_start = 1'b0; we = 1'b0;
        tick();
        chk("save_words", 32'(q_addr.size()), 32'd31);
        for (int i = 0; i < q_addr.size() && i < 31; i++) begin
            chk("save_addr", q_addr[i], 32'(i + 1));
            chk("save_data", q_data[i], 32'h101 + 32'(i));
        end
        chk("save_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Restore with a gap every third cycle; core write mid-transfer is dropped
        d0 = done_cnt;
        restore_start = 1'b1; tick(); restore_start = 1'b0;
        sent = 0; n = 0;
        while (sent < 31 && n < 200) begin
            cv_i = (n % 3 != 2); cd_i = 32'hA000 + 32'(sent + 1);
            we = (n == 4); w_addr = 5'd3; w_data = 32'hFFFF0000;
            tick();
            if (cv_i) sent++;
            n++;
        end
        cv_i = 1'b0; we = 1'b0;
        chk("restore_timeout", 32'(n < 200), 32'd1);
        #1 chk("restore_done_now", 32'(done), 32'd1);
        tick();
        for (int i = 1; i < N; i++) rd_chk("restore_read", i, 32'hA000 + 32'(i));
        chk("restore_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Simultaneous starts -> save; restore request during save ignored; clock-enable freeze
        q_addr.delete(); q_data.delete();
        save_start = 1'b1; restore_start = 1'b1; tick();
        save_start = 1'b0; restore_start = 1'b0;
        #1 chk("coll_valid", 32'(cv_o), 32'd1);
        chk("coll_ready_o", 32'(cr_o), 32'd0);
        cr_i = 1'b1; tick(); tick(); tick();
        restore_start = 1'b1; tick(); restore_start = 1'b0;
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1 chk("freeze_addr", 32'(ctx_addr), 32'd5);
            chk("freeze_data", ctx_data, 32'hA005);
        end
        clk_en = 1'b1;
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        chk("coll_timeout", 32'(n < 100), 32'd1);
        cr_i = 1'b0; tick();
        chk("coll_words", 32'(q_addr.size()), 32'd31);
        for (int i = 0; i < q_addr.size() && i < 31; i++) begin
            chk("coll_addr", q_addr[i], 32'(i + 1));
            chk("coll_data", q_data[i], 32'hA000 + 32'(i + 1));
        end

        // Reset at word 10 of a restore aborts it
        d0 = done_cnt;
        restore_start = 1'b1; tick(); restore_start = 1'b0;
        cv_i = 1'b1;
        for (int i = 0; i < 9; i++) begin cd_i = 32'hC000 + 32'(i + 1); tick(); end
        cd_i = 32'hC00A; rst = 1'b1; tick(); rst = 1'b0; cv_i = 1'b0;
        #1 chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready_o", 32'(cr_o), 32'd0);
        tick(); tick(); tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 1; i < N; i++) rd_chk("abort_read", i, 32'd0);

        // Second instance: NREGS=16, NRD=3, no forwarding
        for (int i = 1; i < N2; i++) begin
            b_we = 1'b1; b_w_addr = 4'(i); b_w_data = 32'h200 + 32'(i); tick();
        end
        b_we = 1'b1; b_w_addr = 4'd5; b_w_data = 32'h12345678;
        b_r_addr = {4'd15, 4'd5, 4'd0};
        #1 chk("b_nobypass", b_r_data[63:32], 32'h205);
        chk("b_port2", b_r_data[95:64], 32'h20F);
        chk("b_port0_x0", b_r_data[31:0], 32'd0);
        tick(); b_we = 1'b0;
        #1 chk("b_after_write", b_r_data[63:32], 32'h12345678);
        bq_addr.delete(); bq_data.delete();
        b_save_start = 1'b1; tick(); b_save_start = 1'b0;
        b_cr_i = 1'b1; n = 0;
        while (!b_done && n < 100) begin tick(); n++; end
        chk("b_latency", 32'(n), 32'd15);
        b_cr_i = 1'b0; tick();
        chk("b_words", 32'(bq_addr.size()), 32'd15);
        for (int i = 0; i < bq_addr.size() && i < 15; i++) begin
            chk("b_addr", bq_addr[i], 32'(i + 1));
            chk("b_data", bq_data[i], (i == 4) ? 32'h12345678 : 32'h201 + 32'(i));
        end
        #1 chk("b_idle_busy", 32'(b_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
